// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the access controller (master) and the memory (slave).
// Pure wiring: no latency. The master holds request/address/data until the slave returns a one-cycle ack.
interface dmem_access_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences the EX/MEM load/store onto a multi-cycle data memory; optional watchdog via MEM_TIMEOUT_EN.
// Latency: ack in the k-th ACCESS cycle -> stall for k+1 cycles, DONE one cycle later.
// Backpressure: stall_o freezes the pipeline from op detection until DONE; the memory throttles via ack.
module dmem_access_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 memRead_i,
    input  logic                 memWrite_i,
    input  logic [DATA_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    dmem_access_ctrl_if.master   mem,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 stall_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     stallCnt_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_we;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_op;
    logic               w_stall;
    logic               w_timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;

    // The ack has priority: expiry only counts when no ack arrives on the last cycle.
    assign w_timeout = (r_state == S_ACCESS) && !mem.mem_ack_i &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_o     = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign w_op = memRead_i | memWrite_i;

    // Stall in IDLE is combinational so the op is frozen in EX/MEM on the very cycle it appears;
    // gating with reset keeps every output low while reset is held.
    assign w_stall = rst_i && (((r_state == S_IDLE) && w_op) || (r_state == S_ACCESS));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
`ifdef MEM_TIMEOUT_EN
            r_tmo   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                    r_err <= 1'b0;
                    r_tmo <= '0;
`endif
                    if (w_op) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_we    <= memWrite_i;
                        r_req   <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (mem.mem_ack_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_rdata <= mem.mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
`ifdef MEM_TIMEOUT_EN
                        r_err   <= 1'b1;
`endif
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
`endif
                end

                // The op is deliberately not sampled here: EX/MEM still holds the finished access.
                S_DONE: begin
`ifdef MEM_TIMEOUT_EN
                    r_err <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req_o   = r_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;
    assign rdata_o         = r_rdata;
    assign stall_o         = w_stall;
    assign stallCnt_o      = r_cnt;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expected requests/completions, a negedge monitor compares.
module tb_dmem_access_ctrl;
    localparam int DW  = 32;
    localparam int CW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memRead, memWrite;
    logic [DW-1:0] addr, wdata;
    logic [DW-1:0] rdata;
    logic          stall, err;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.DATA_W(DW)) mif ();

    dmem_access_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .memRead_i  (memRead),
        .memWrite_i (memWrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .mem        (mif),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .err_o      (err),
        .stallCnt_o (cnt)
    );

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic [CW-1:0] cnt;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last loaded word and total stalled cycles.
    logic [DW-1:0] m_rdata;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: request rising edge -> compare issued access; request falling edge -> compare completion.
    logic prev_req = 1'b0;
    req_t cur;
    cpl_t cc;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (mif.mem_req_o && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 64'd1, 64'd0);
                end else begin
                    cur = req_q.pop_front();
                    chk("req_we",    64'(mif.mem_we_o),    64'(cur.we));
                    chk("req_addr",  64'(mif.mem_addr_o),  64'(cur.addr));
                    chk("req_wdata", 64'(mif.mem_wdata_o), 64'(cur.wdata));
                end
            end else if (mif.mem_req_o) begin
                chk("req_addr_stable", 64'(mif.mem_addr_o), 64'(cur.addr));
                chk("access_stall",    64'(stall),          64'd1);
            end else if (prev_req) begin
                if (cpl_q.size() == 0) begin
                    chk("unexpected_cpl", 64'd1, 64'd0);
                end else begin
                    cc = cpl_q.pop_front();
                    chk("cpl_rdata", 64'(rdata), 64'(cc.rdata));
                    chk("cpl_err",   64'(err),   64'(cc.err));
                    chk("cpl_cnt",   64'(cnt),   64'(cc.cnt));
                    chk("cpl_stall", 64'(stall), 64'd0);
                end
            end
            prev_req = mif.mem_req_o;
        end
    end

    // Issue one op in the next cycle (FSM must be IDLE there); ack arrives in ACCESS cycle d.
    // Returns in the DONE cycle with the op still held on the inputs.
    task automatic do_op(input logic rd, input logic wr, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rdv);
        req_t r;
        cpl_t c;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; addr = a; wdata = wd;
        r.we = wr; r.addr = a; r.wdata = wd;
        req_q.push_back(r);
        if (!wr) m_rdata = rdv;
        m_cnt   = m_cnt + CW'(d + 1);
        c.rdata = m_rdata; c.err = 1'b0; c.cnt = m_cnt;
        cpl_q.push_back(c);
        #1 chk("idle_op_stall", 64'(stall), 64'd1);
        for (int i = 1; i <= d; i++) begin
            @(posedge clk); #1;
            mif.mem_ack_i   = (i == d);
            mif.mem_rdata_i = (i == d) ? rdv : $urandom;
        end
        @(posedge clk); #1;
        mif.mem_ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            memRead = 1'b0; memWrite = 1'b0;
            #1 chk("idle_stall", 64'(stall), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int            kind;
        memRead = 0; memWrite = 0; addr = '0; wdata = '0;
        mif.mem_ack_i = 1'b0; mif.mem_rdata_i = '0;
        m_rdata = '0; m_cnt = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   64'(mif.mem_req_o),   64'd0);
        chk("rst_we",    64'(mif.mem_we_o),    64'd0);
        chk("rst_addr",  64'(mif.mem_addr_o),  64'd0);
        chk("rst_wdata", 64'(mif.mem_wdata_o), 64'd0);
        chk("rst_rdata", 64'(rdata),           64'd0);
        chk("rst_stall", 64'(stall),           64'd0);
        chk("rst_err",   64'(err),             64'd0);
        chk("rst_cnt",   64'(cnt),             64'd0);
        rst_n = 1'b1;

        // Directed: load with 3-cycle ack, then store acked immediately.
        do_op(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h1234_5678);
        chk("t1_rdata", 64'(rdata), 64'h1234_5678);
        chk("t1_cnt",   64'(cnt),   64'd4);
        idle(1);
        do_op(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1, 32'hDEAD_BEEF);
        chk("t2_rdata", 64'(rdata), 64'h1234_5678);
        chk("t2_cnt",   64'(cnt),   64'd6);
        idle(1);

        // Back-to-back with op held through DONE; a re-issue would show as unexpected_req.
        do_op(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hA5A5_0001);
        do_op(1'b0, 1'b1, 32'h104, 32'h77, 2, 32'h0);
        idle(1);

        // Both strobes: write wins. Then a stray ack in IDLE.
        do_op(1'b1, 1'b1, 32'h200, 32'h55, 2, 32'hBAD0_BAD0);
        idle(1);
        @(posedge clk); #1;
        mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hFFFF_0000;
        @(posedge clk); #1;
        mif.mem_ack_i = 1'b0;
        #1;
        chk("stray_req",   64'(mif.mem_req_o), 64'd0);
        chk("stray_stall", 64'(stall),         64'd0);
        chk("stray_rdata", 64'(rdata),         64'(m_rdata));

        // Reset in the middle of ACCESS, late ack afterwards.
        @(posedge clk); #1;
        memRead = 1'b1; addr = 32'h300;
        cur.we = 1'b0; cur.addr = 32'h300; cur.wdata = wdata;
        req_q.push_back(cur);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   64'(mif.mem_req_o), 64'd0);
        chk("mid_rst_stall", 64'(stall),         64'd0);
        chk("mid_rst_cnt",   64'(cnt),           64'd0);
        memRead = 1'b0;
        m_cnt = '0; m_rdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h1357_9BDF;
        @(posedge clk); #1;
        mif.mem_ack_i = 1'b0;
        #1;
        chk("late_ack_req",   64'(mif.mem_req_o), 64'd0);
        chk("late_ack_stall", 64'(stall),         64'd0);
        chk("late_ack_rdata", 64'(rdata),         64'd0);
        do_op(1'b1, 1'b0, 32'h304, 32'h0, 1, 32'h2468_ACE0);
        idle(1);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TMO ACCESS cycles with a one-cycle error.
        begin
            cpl_t c;
            @(posedge clk); #1;
            memRead = 1'b1; memWrite = 1'b0; addr = 32'h400;
            cur.we = 1'b0; cur.addr = 32'h400; cur.wdata = wdata;
            req_q.push_back(cur);
            m_cnt = m_cnt + CW'(TMO + 1);
            c.rdata = m_rdata; c.err = 1'b1; c.cnt = m_cnt;
            cpl_q.push_back(c);
            repeat (TMO) begin
                @(posedge clk); #1;
                chk("tmo_wait_err", 64'(err), 64'd0);
            end
            @(posedge clk); #1;
            chk("tmo_err",   64'(err),   64'd1);
            chk("tmo_rdata", 64'(rdata), 64'(m_rdata));
            idle(1);
            chk("tmo_err_pulse", 64'(err), 64'd0);
        end
`else
        // No ack for a long time: the access just waits.
        begin
            cpl_t c;
            v = $urandom;
            @(posedge clk); #1;
            memRead = 1'b1; memWrite = 1'b0; addr = 32'h400;
            cur.we = 1'b0; cur.addr = 32'h400; cur.wdata = wdata;
            req_q.push_back(cur);
            m_rdata = v;
            m_cnt = m_cnt + CW'(TMO + 5);
            c.rdata = m_rdata; c.err = 1'b0; c.cnt = m_cnt;
            cpl_q.push_back(c);
            repeat (TMO + 4) begin
                @(posedge clk); #1;
                chk("notmo_stall", 64'(stall), 64'd1);
                chk("notmo_err",   64'(err),   64'd0);
            end
            mif.mem_ack_i = 1'b1; mif.mem_rdata_i = v;
            @(posedge clk); #1;
            mif.mem_ack_i = 1'b0;
            idle(1);
        end
`endif

        // Ack on the last cycle before a watchdog would fire: normal completion.
        do_op(1'b1, 1'b0, 32'h500, 32'h0, TMO, 32'h0F0F_0F0F);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            v    = $urandom;
            do_op(kind != 1, kind != 0, {$urandom_range(0, 32'h3FFF), 2'b00},
                  $urandom, $urandom_range(1, 6), v);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(2);
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("cpl_q_drained", 64'(cpl_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
